// File: rtl/lbist_pkg.sv
// Shared types and default constants for the LBIST MISR compaction controller.
// Defaults target a 17-bit response bus (x^17+x^3+1) and 1000 patterns per session.
package lbist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } lbist_state_t;

  localparam int          DEFAULT_W    = 17;
  localparam logic [16:0] DEFAULT_POLY = 17'h00009;
  localparam int          DEFAULT_NPAT = 1000;
  localparam int          DEFAULT_CW   = 16;

endpackage

// File: rtl/lbist_misr_ctrl_misr_core.sv
// Combinational MISR step: shift left, fold in the response word, and apply tap feedback from the MSB.
// Zero latency; no flow control, purely a function of its inputs.
module misr_core #(
  parameter int           W    = 17,
  parameter logic [W-1:0] POLY = 17'h00009
) (
  input  logic [W-1:0] i_sig,
  input  logic [W-1:0] i_resp,
  output logic [W-1:0] o_next
);

  always_comb begin
    o_next    = '0;
    // Stage 0 has no upstream stage, so it takes the feedback bit unconditionally.
    o_next[0] = i_resp[0] ^ i_sig[W-1];
    for (int i = 1; i < W; i++) begin
      o_next[i] = i_sig[i-1] ^ i_resp[i] ^ (POLY[i] & i_sig[W-1]);
    end
  end

endmodule

// File: rtl/lbist_misr_ctrl.sv
// LBIST session controller: compacts NPAT valid responses into a MISR and compares against golden.
// done/pass/final signature appear one cycle after the last valid response; resp_valid gaps stall the count.
module lbist_misr_ctrl
  import lbist_pkg::*;
#(
  parameter int           W    = DEFAULT_W,
  parameter logic [W-1:0] POLY = DEFAULT_POLY,
  parameter int           NPAT = DEFAULT_NPAT,
  parameter int           CW   = DEFAULT_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  seed,
  input  logic [W-1:0]  golden,
  input  logic          resp_valid,
  input  logic [W-1:0]  resp,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [W-1:0]  signature,
  output logic [CW-1:0] pat_count
);

  lbist_state_t  r_state;
  lbist_state_t  w_state_nxt;
  logic [W-1:0]  r_sig;
  logic [W-1:0]  w_sig_nxt;
  logic [W-1:0]  w_misr;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          r_pass;
  logic          w_pass_nxt;

  misr_core #(
    .W    (W),
    .POLY (POLY)
  ) u_misr_core (
    .i_sig  (r_sig),
    .i_resp (resp),
    .o_next (w_misr)
  );

  assign w_cnt_inc = r_cnt + CW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_sig_nxt   = r_sig;
    w_cnt_nxt   = r_cnt;
    w_pass_nxt  = r_pass;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_sig_nxt   = seed;
          w_cnt_nxt   = '0;
          w_pass_nxt  = 1'b0;
        end
      end
      ST_RUN: begin
        if (resp_valid) begin
          w_sig_nxt = w_misr;
          w_cnt_nxt = w_cnt_inc;
          // Leaving RUN on the terminal response keeps the counter from ever wrapping.
          if (w_cnt_inc == CW'(NPAT)) begin
            w_state_nxt = ST_DONE;
            w_pass_nxt  = (w_misr == golden);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_sig   <= '0;
      r_cnt   <= '0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sig   <= w_sig_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pass  <= w_pass_nxt;
    end
  end

  assign busy      = (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);
  assign pass      = r_pass;
  assign signature = r_sig;
  assign pat_count = r_cnt;

endmodule

// File: tb/tb_lbist_misr_ctrl.sv
// Directed bench for lbist_misr_ctrl at W=4, POLY=4'h3, NPAT=3, CW=4.
// Expected signatures are hand-derived from the MISR recurrence.
module tb_lbist_misr_ctrl;

  localparam int W  = 4;
  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic          start;
  logic [W-1:0]  seed;
  logic [W-1:0]  golden;
  logic          resp_valid;
  logic [W-1:0]  resp;
  logic          busy;
  logic          done;
  logic          pass;
  logic [W-1:0]  signature;
  logic [CW-1:0] pat_count;

  int checks = 0;
  int errors = 0;

  lbist_misr_ctrl #(
    .W    (W),
    .POLY (4'h3),
    .NPAT (3),
    .CW   (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .seed       (seed),
    .golden     (golden),
    .resp_valid (resp_valid),
    .resp       (resp),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .signature  (signature),
    .pat_count  (pat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic b, input logic d, input logic p,
                           input logic [W-1:0] s, input logic [CW-1:0] c);
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".done"}, 32'(done), 32'(d));
    check({tag, ".pass"}, 32'(pass), 32'(p));
    check({tag, ".sig"},  32'(signature), 32'(s));
    check({tag, ".cnt"},  32'(pat_count), 32'(c));
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    seed       = '0;
    golden     = '0;
    resp_valid = 1'b0;
    resp       = '0;
    #2;
    check_all("reset", 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_all("idle", 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);

    // Basic compaction: 1,0,0 from seed 0 gives 1,2,4
    seed = 4'h0; golden = 4'h4; start = 1'b1;
    tick();
    start = 1'b0;
    check_all("basic.load", 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    resp_valid = 1'b1; resp = 4'h1;
    tick();
    check("basic.sig1", 32'(signature), 32'h1);
    resp = 4'h0;
    tick();
    check("basic.sig2", 32'(signature), 32'h2);
    tick();
    check_all("basic.done", 1'b0, 1'b1, 1'b1, 4'h4, 4'h3);
    resp = 4'hF;
    tick();
    check_all("basic.hold", 1'b0, 1'b1, 1'b1, 4'h4, 4'h3);
    resp_valid = 1'b0;

    // Mismatch: same stimulus, golden 5
    seed = 4'h0; golden = 4'h5; start = 1'b1;
    tick();
    start = 1'b0;
    check_all("mis.load", 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    resp_valid = 1'b1; resp = 4'h1;
    tick();
    resp = 4'h0;
    tick();
    tick();
    resp_valid = 1'b0;
    check_all("mis.done", 1'b0, 1'b1, 1'b0, 4'h4, 4'h3);

    // Restart from DONE with seed 8, then feedback wrap 8 -> 3 -> 6 -> C
    seed = 4'h8; start = 1'b1;
    tick();
    start = 1'b0;
    check_all("restart", 1'b1, 1'b0, 1'b0, 4'h8, 4'h0);
    resp_valid = 1'b1; resp = 4'h0;
    tick();
    check("wrap.sig", 32'(signature), 32'h3);
    check("wrap.cnt", 32'(pat_count), 32'h1);
    tick();
    check("wrap.sig2", 32'(signature), 32'h6);
    tick();
    resp_valid = 1'b0;
    check_all("wrap.done", 1'b0, 1'b1, 1'b0, 4'hC, 4'h3);

    // Bubbles with a start pulse mid-run; garbage resp during bubbles
    seed = 4'h0; golden = 4'h4; start = 1'b1;
    tick();
    start = 1'b0;
    resp_valid = 1'b1; resp = 4'h1;
    tick();
    resp_valid = 1'b0; resp = 4'hF; start = 1'b1; seed = 4'h8;
    tick();
    start = 1'b0;
    check_all("bub.mid", 1'b1, 1'b0, 1'b0, 4'h1, 4'h1);
    resp_valid = 1'b1; resp = 4'h0;
    tick();
    resp_valid = 1'b0; resp = 4'hA;
    tick();
    check_all("bub.gap", 1'b1, 1'b0, 1'b0, 4'h2, 4'h2);
    resp_valid = 1'b1; resp = 4'h0;
    tick();
    resp_valid = 1'b0;
    check_all("bub.done", 1'b0, 1'b1, 1'b1, 4'h4, 4'h3);

    // Reset mid-run after two responses
    seed = 4'h0; start = 1'b1;
    tick();
    start = 1'b0;
    resp_valid = 1'b1; resp = 4'h1;
    tick();
    resp = 4'h0;
    tick();
    resp_valid = 1'b0;
    check("rst.pre_cnt", 32'(pat_count), 32'h2);
    reset = 1'b1;
    #1;
    check_all("rst.async", 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    start = 1'b1;
    tick();
    check_all("rst.held", 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    reset = 1'b0; start = 1'b0;
    tick();
    check_all("rst.idle", 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    seed = 4'h0; golden = 4'h4; start = 1'b1;
    tick();
    start = 1'b0;
    resp_valid = 1'b1; resp = 4'h1;
    tick();
    resp = 4'h0;
    tick();
    tick();
    resp_valid = 1'b0;
    check_all("rst.rerun", 1'b0, 1'b1, 1'b1, 4'h4, 4'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
